// File: rtl/fht_but_pipe_pkg.sv
// Shared constants for the FHT butterfly lane.
package fht_but_pipe_pkg;

   localparam int unsigned ADC_WIDTH  = 14;
   localparam int unsigned D_BIT_DEF  = 17;
   localparam int unsigned W_BIT_DEF  = 12;
   localparam int unsigned W_FRAC_DEF = 10;

   // Mixer test build: arithmetic bypassed, Y0 = X0, Y1 = X1, latency kept.
   localparam bit TEST_MIXER = 1'b0;

   // Coefficient code representing 1.0 for a given number of fractional bits.
   function automatic int unsigned coef_one(input int unsigned frac);
      return 32'(1) << frac;
   endfunction

   localparam int unsigned COEF_ONE = coef_one(W_FRAC_DEF);

endpackage

// File: rtl/fht_round_sat.sv
// Fixed-point to integer conversion: shift right, round half away from zero, saturate.
module fht_round_sat
   import fht_but_pipe_pkg::*;
#(
   parameter int unsigned IN_W  = 31,
   parameter int unsigned OUT_W = 17,
   parameter int unsigned FRAC  = 10
) (
   input  logic signed [IN_W-1:0]  i_val,
   input  logic                    i_shift,
   output logic signed [OUT_W-1:0] o_y_c,
   output logic                    o_ovf_c
);

   localparam int unsigned XW = IN_W + 1;
   localparam logic signed [XW-1:0] MAX_V = (XW'(1) <<< (OUT_W - 1)) - XW'(1);
   localparam logic signed [XW-1:0] MIN_V = -(XW'(1) <<< (OUT_W - 1));

   logic signed [XW-1:0] w_ext;
   logic signed [XW-1:0] w_bias;
   logic signed [XW-1:0] w_q;

   // Negative values take a bias one LSB short of half so that floor-shifting rounds ties away from zero.
   always_comb begin
      w_ext  = XW'(i_val);
      w_bias = i_shift ? (XW'(1) <<< FRAC) : (XW'(1) <<< (FRAC - 1));
      if (i_val[IN_W-1]) begin
         w_bias = w_bias - XW'(1);
      end
      w_q     = i_shift ? ((w_ext + w_bias) >>> (FRAC + 1)) : ((w_ext + w_bias) >>> FRAC);
      o_ovf_c = (w_q > MAX_V) || (w_q < MIN_V);
      o_y_c   = w_q[OUT_W-1:0];
      if (w_q > MAX_V) begin
         o_y_c = MAX_V[OUT_W-1:0];
      end else if (w_q < MIN_V) begin
         o_y_c = MIN_V[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/fht_but_pipe.sv
// Three-stage pipelined radix-2 Hartley butterfly with stall, bypass, scaling and saturation.
module fht_but_pipe
   import fht_but_pipe_pkg::*;
#(
   parameter int unsigned D_BIT  = D_BIT_DEF,
   parameter int unsigned W_BIT  = W_BIT_DEF,
   parameter int unsigned W_FRAC = W_FRAC_DEF
) (
   input  logic                    iCLK,
   input  logic                    iRESET,
   input  logic                    iEN,
   input  logic                    iVALID,
   input  logic                    iBYPASS,
   input  logic                    iSHIFT,
   input  logic signed [D_BIT-1:0] iX_0,
   input  logic signed [D_BIT-1:0] iX_1,
   input  logic signed [D_BIT-1:0] iX_2,
   input  logic signed [W_BIT-1:0] iSIN,
   input  logic signed [W_BIT-1:0] iCOS,
   input  logic                    iOVF_CLR,
   output logic signed [D_BIT-1:0] oY_0,
   output logic signed [D_BIT-1:0] oY_1,
   output logic                    oVALID,
   output logic                    oOVF
);

   localparam int unsigned PW = D_BIT + W_BIT;
   localparam int unsigned MW = PW + 1;
   localparam int unsigned SW = MW + 1;

   logic                    w_bypass;
   logic signed [PW-1:0]    w_p1;
   logic signed [PW-1:0]    w_p2;
   logic signed [SW-1:0]    w_s;
   logic signed [SW-1:0]    w_d;
   logic                    w_shift;
   logic signed [D_BIT-1:0] w_y0;
   logic signed [D_BIT-1:0] w_y1;
   logic                    w_ovf0;
   logic                    w_ovf1;

   logic signed [PW-1:0]    r_p1;
   logic signed [PW-1:0]    r_p2;
   logic signed [D_BIT-1:0] r_x0;
   logic                    r_v1;
   logic                    r_sh1;
   logic signed [MW-1:0]    r_m;
   logic signed [MW-1:0]    r_e;
   logic                    r_v2;
   logic                    r_sh2;
   logic signed [D_BIT-1:0] r_y0;
   logic signed [D_BIT-1:0] r_y1;
   logic                    r_v3;
   logic                    r_ovf;

   assign w_bypass = iBYPASS | TEST_MIXER;

   // Stage-1 product terms; bypass substitutes X1 scaled by exactly 1.0.
   always_comb begin
      w_p1 = PW'(iX_1) * PW'(iCOS);
      w_p2 = PW'(iX_2) * PW'(iSIN);
      if (w_bypass) begin
         w_p1 = PW'(iX_1) <<< W_FRAC;
         w_p2 = '0;
      end
   end

   // S1: products, with X0 / valid / shift delayed alongside.
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         r_p1  <= '0;
         r_p2  <= '0;
         r_x0  <= '0;
         r_v1  <= 1'b0;
         r_sh1 <= 1'b0;
      end else if (iEN) begin
         r_p1  <= w_p1;
         r_p2  <= w_p2;
         r_x0  <= iX_0;
         r_v1  <= iVALID;
         r_sh1 <= iSHIFT;
      end
   end

   // S2: combined product and X0 aligned to the coefficient binary point.
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         r_m   <= '0;
         r_e   <= '0;
         r_v2  <= 1'b0;
         r_sh2 <= 1'b0;
      end else if (iEN) begin
         r_m   <= MW'(r_p1) + MW'(r_p2);
         r_e   <= MW'(r_x0) <<< W_FRAC;
         r_v2  <= r_v1;
         r_sh2 <= r_sh1;
      end
   end

   // S3 sum / difference at full width; the mixer build passes the operands through.
   always_comb begin
      w_s     = TEST_MIXER ? SW'(r_e) : SW'(r_e) + SW'(r_m);
      w_d     = TEST_MIXER ? SW'(r_m) : SW'(r_e) - SW'(r_m);
      w_shift = r_sh2 & ~TEST_MIXER;
   end

   fht_round_sat #(.IN_W(SW), .OUT_W(D_BIT), .FRAC(W_FRAC)) u_rs_sum (
      .i_val   (w_s),
      .i_shift (w_shift),
      .o_y_c   (w_y0),
      .o_ovf_c (w_ovf0)
   );

   fht_round_sat #(.IN_W(SW), .OUT_W(D_BIT), .FRAC(W_FRAC)) u_rs_dif (
      .i_val   (w_d),
      .i_shift (w_shift),
      .o_y_c   (w_y1),
      .o_ovf_c (w_ovf1)
   );

   // S3: rounded, saturated results and output valid.
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         r_y0 <= '0;
         r_y1 <= '0;
         r_v3 <= 1'b0;
      end else if (iEN) begin
         r_y0 <= w_y0;
         r_y1 <= w_y1;
         r_v3 <= r_v2;
      end
   end

   // Sticky overflow: a new valid saturation beats a simultaneous clear; clear works while stalled.
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         r_ovf <= 1'b0;
      end else if (iEN && r_v2 && (w_ovf0 || w_ovf1)) begin
         r_ovf <= 1'b1;
      end else if (iOVF_CLR) begin
         r_ovf <= 1'b0;
      end
   end

   assign oY_0   = r_y0;
   assign oY_1   = r_y1;
   assign oVALID = r_v3;
   assign oOVF   = r_ovf;

endmodule

// File: tb/tb_fht_but_pipe.sv
// Self-checking bench for fht_but_pipe: arithmetic reference model plus directed vectors.
module tb_fht_but_pipe;

   localparam int unsigned D = 17;
   localparam int unsigned W = 12;
   localparam int unsigned F = 10;
   localparam longint MAXV = (longint'(1) <<< (D - 1)) - 1;
   localparam longint MINV = -(longint'(1) <<< (D - 1));

   logic                iCLK;
   logic                iRESET;
   logic                tb_en;
   logic                tb_v;
   logic                tb_byp;
   logic                tb_sh;
   logic signed [D-1:0] tb_x0;
   logic signed [D-1:0] tb_x1;
   logic signed [D-1:0] tb_x2;
   logic signed [W-1:0] tb_sin;
   logic signed [W-1:0] tb_cos;
   logic                tb_clr;
   logic signed [D-1:0] oY_0;
   logic signed [D-1:0] oY_1;
   logic                oVALID;
   logic                oOVF;

   int checks = 0;
   int errors = 0;

   fht_but_pipe #(.D_BIT(D), .W_BIT(W), .W_FRAC(F)) dut (
      .iCLK     (iCLK),
      .iRESET   (iRESET),
      .iEN      (tb_en),
      .iVALID   (tb_v),
      .iBYPASS  (tb_byp),
      .iSHIFT   (tb_sh),
      .iX_0     (tb_x0),
      .iX_1     (tb_x1),
      .iX_2     (tb_x2),
      .iSIN     (tb_sin),
      .iCOS     (tb_cos),
      .iOVF_CLR (tb_clr),
      .oY_0     (oY_0),
      .oY_1     (oY_1),
      .oVALID   (oVALID),
      .oOVF     (oOVF)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   typedef struct {
      longint y0;
      longint y1;
      bit     v;
      bit     sat;
   } exp_t;

   exp_t   q[$];
   exp_t   m_e;
   exp_t   m_o;
   longint m_y0 = 0;
   longint m_y1 = 0;
   bit     m_v = 1'b0;
   bit     m_ovf = 1'b0;
   longint rec[$];

   // Exact rational value n / 2^(F+sh), rounded half away from zero.
   function automatic longint rnd(input longint n, input bit sh);
      longint den;
      longint a;
      longint r;
      den = longint'(1) <<< (F + int'(sh));
      a   = (n < 0) ? -n : n;
      r   = (a + den / 2) / den;
      return (n < 0) ? -r : r;
   endfunction

   function automatic longint clamp(input longint v);
      if (v > MAXV) return MAXV;
      if (v < MINV) return MINV;
      return v;
   endfunction

   function automatic exp_t model(input longint x0, x1, x2, c, s, input bit byp, sh);
      exp_t   r;
      longint one;
      longint p;
      longint a0;
      longint a1;
      one   = longint'(1) <<< F;
      p     = byp ? x1 * one : x1 * c + x2 * s;
      a0    = rnd(x0 * one + p, sh);
      a1    = rnd(x0 * one - p, sh);
      r.sat = (a0 != clamp(a0)) || (a1 != clamp(a1));
      r.y0  = clamp(a0);
      r.y1  = clamp(a1);
      r.v   = 1'b0;
      return r;
   endfunction

   // Reference: each enabled edge accepts a triple; it appears three enabled edges later.
   always @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         q.delete();
         m_y0  = 0;
         m_y1  = 0;
         m_v   = 1'b0;
         m_ovf = 1'b0;
      end else begin
         m_o.v   = 1'b0;
         m_o.sat = 1'b0;
         if (tb_en) begin
            m_e   = model(longint'(tb_x0), longint'(tb_x1), longint'(tb_x2),
                          longint'(tb_cos), longint'(tb_sin), tb_byp, tb_sh);
            m_e.v = tb_v;
            q.push_back(m_e);
            if (q.size() >= 3) begin
               m_o  = q.pop_front();
               m_y0 = m_o.y0;
               m_y1 = m_o.y1;
               m_v  = m_o.v;
            end
         end
         if (m_o.v && m_o.sat) m_ovf = 1'b1;
         else if (tb_clr)      m_ovf = 1'b0;
      end
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model.
   always @(posedge iCLK) begin
      #2;
      chk("m_valid", longint'(oVALID), longint'(m_v));
      chk("m_ovf", longint'(oOVF), longint'(m_ovf));
      if (m_v) begin
         chk("m_y0", longint'(oY_0), m_y0);
         chk("m_y1", longint'(oY_1), m_y1);
      end
   end

   // Records each result delivered on an enabled edge, for order / duplication checks.
   always @(posedge iCLK) begin
      if (tb_en && iRESET) begin
         #2;
         if (oVALID) rec.push_back(longint'(oY_0));
      end
   end

   task automatic drive(input longint x0, x1, x2, c, s, input bit byp, sh, v);
      tb_x0  = D'(x0);
      tb_x1  = D'(x1);
      tb_x2  = D'(x2);
      tb_cos = W'(c);
      tb_sin = W'(s);
      tb_byp = byp;
      tb_sh  = sh;
      tb_v   = v;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   // One isolated triple; literal results checked after the third edge.
   task automatic run_one(input longint x0, x1, x2, c, s, input bit byp, sh,
                          input longint e0, e1, input string nm);
      @(negedge iCLK);
      drive(x0, x1, x2, c, s, byp, sh, 1'b1);
      @(posedge iCLK);
      #1 idle();
      @(posedge iCLK);
      @(posedge iCLK);
      #3;
      chk({nm, "_y0"}, longint'(oY_0), e0);
      chk({nm, "_y1"}, longint'(oY_1), e1);
      chk({nm, "_v"}, longint'(oVALID), 1);
   endtask

   initial begin
      iRESET = 1'b0;
      tb_en  = 1'b1;
      tb_clr = 1'b0;
      idle();
      repeat (2) @(negedge iCLK);
      chk("rst_y0", longint'(oY_0), 0);
      chk("rst_v", longint'(oVALID), 0);
      chk("rst_ovf", longint'(oOVF), 0);
      iRESET = 1'b1;

      run_one(100, 200, 0, 1024, 0, 1'b0, 1'b0, 300, -100, "basic");
      chk("basic_ovf", longint'(oOVF), 0);
      run_one(0, 3, 0, 512, 0, 1'b0, 1'b0, 2, -2, "rnd15");
      run_one(0, 5, 0, 256, 0, 1'b0, 1'b0, 1, -1, "rnd125");
      run_one(0, -3, 0, 512, 0, 1'b0, 1'b0, -2, 2, "rnd_neg");
      run_one(65535, 65535, 0, 1024, 0, 1'b0, 1'b0, 65535, 0, "sat");
      chk("ovf_set", longint'(oOVF), 1);

      for (int i = 0; i < 10; i++) begin
         @(negedge iCLK);
         drive(i, 2 * i, 0, 1024, 0, 1'b0, 1'b0, 1'b1);
      end
      @(negedge iCLK);
      idle();
      repeat (3) @(posedge iCLK);
      #3 chk("ovf_sticky", longint'(oOVF), 1);

      @(negedge iCLK);
      tb_clr = 1'b1;
      @(posedge iCLK);
      #1 tb_clr = 1'b0;
      #2 chk("ovf_clr", longint'(oOVF), 0);

      // Clear coincident with a fresh overflow reaching the output stage.
      @(negedge iCLK);
      drive(65535, 65535, 0, 1024, 0, 1'b0, 1'b0, 1'b1);
      @(posedge iCLK);
      #1 idle();
      @(posedge iCLK);
      #1 tb_clr = 1'b1;
      @(posedge iCLK);
      #3 chk("ovf_set_wins", longint'(oOVF), 1);
      tb_clr = 1'b0;

      // Clear while stalled.
      @(negedge iCLK);
      tb_en  = 1'b0;
      tb_clr = 1'b1;
      @(posedge iCLK);
      #1 tb_clr = 1'b0;
      tb_en = 1'b1;
      #2 chk("ovf_clr_stall", longint'(oOVF), 0);

      run_one(10, -4, 999, 300, 777, 1'b1, 1'b0, 6, 14, "byp");
      run_one(5, 0, 0, 0, 0, 1'b1, 1'b1, 3, 3, "byp_shift");
      run_one(-7, 9, 0, 1024, 0, 1'b0, 1'b1, 1, -8, "shift_neg");

      // Back-to-back mixed vectors, checked by the model.
      @(negedge iCLK); drive(1000, -2000, 3000, -700, 1500, 1'b0, 1'b1, 1'b1);
      @(negedge iCLK); drive(-500, 1234, -4321, 2047, -2048, 1'b0, 1'b0, 1'b1);
      @(negedge iCLK); drive(3, 7, 11, 333, 444, 1'b0, 1'b0, 1'b0);
      @(negedge iCLK); drive(-65536, 100, 100, 1000, -1000, 1'b0, 1'b1, 1'b1);
      @(negedge iCLK); drive(40000, 30000, 30000, 1024, 1024, 1'b0, 1'b0, 1'b1);
      @(negedge iCLK); drive(-1, -1, -1, 513, 511, 1'b0, 1'b0, 1'b1);
      @(negedge iCLK); idle();
      repeat (4) @(negedge iCLK);
      tb_clr = 1'b1;
      @(negedge iCLK);
      tb_clr = 1'b0;

      // Stall mid-stream: results must come out once each, in order.
      rec.delete();
      for (int i = 1; i <= 4; i++) begin
         @(negedge iCLK);
         drive(i, i, 0, 1024, 0, 1'b0, 1'b0, 1'b1);
         if (i == 2) begin
            @(negedge iCLK);
            tb_en = 1'b0;
            for (int k = 0; k < 5; k++) begin
               drive(123 + k, 456, 789, 1000, 1000, 1'b0, 1'b0, 1'b1);
               @(negedge iCLK);
            end
            tb_en = 1'b1;
            drive(i + 1, i + 1, 0, 1024, 0, 1'b0, 1'b0, 1'b1);
            i++;
         end
      end
      @(negedge iCLK);
      idle();
      repeat (4) @(negedge iCLK);
      chk("stall_count", longint'(rec.size()), 4);
      for (int i = 0; i < 4; i++) begin
         chk("stall_order", (i < rec.size()) ? rec[i] : -1, longint'(2 * (i + 1)));
      end

      // Reset mid-operation with the pipeline full and overflow set.
      run_one(-65536, -65536, 0, 1024, 0, 1'b0, 1'b0, -65536, 0, "sat_neg");
      chk("ovf_neg", longint'(oOVF), 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge iCLK);
         drive(20 + i, 5, 0, 1024, 0, 1'b0, 1'b0, 1'b1);
      end
      @(posedge iCLK);
      #2;
      #2 iRESET = 1'b0;
      #1;
      chk("arst_y0", longint'(oY_0), 0);
      chk("arst_y1", longint'(oY_1), 0);
      chk("arst_v", longint'(oVALID), 0);
      chk("arst_ovf", longint'(oOVF), 0);
      @(negedge iCLK);
      iRESET = 1'b1;
      drive(7, 8, 0, 1024, 0, 1'b0, 1'b0, 1'b1);
      @(posedge iCLK);
      #1 idle();
      #2 chk("post_rst_v1", longint'(oVALID), 0);
      @(posedge iCLK);
      #3 chk("post_rst_v2", longint'(oVALID), 0);
      @(posedge iCLK);
      #3;
      chk("post_rst_y0", longint'(oY_0), 15);
      chk("post_rst_y1", longint'(oY_1), -1);
      chk("post_rst_v3", longint'(oVALID), 1);

      repeat (3) @(negedge iCLK);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
